approx_adder_err_monitor: RTL
=============================

// Module: approx_adder_err_monitor
// PURPOSE
//  Synthesisable in-circuit error monitor for approximate adders (ACA, ETA, GeAr, GDA, LOA, RCA variants).
//  Accepts operand pairs, the add/sub mode and the approximate adder's result over a valid/ready handshake.
//  Computes the exact result internally and accumulates error statistics over a programmed sample count:
//  sum of |error|, max |error|, count of erroneous samples.
//  Sits beside an Approx_adder instance on silicon/FPGA so error metrics need no waveform dump.
// PARAMETERS
//  W      26   operand width; the result is W+1 bits
//  CNT_W  20   sample counter width; at most 2^CNT_W-1 samples per run
//  ACC_W  W+1+CNT_W  error-sum width (localparam; overflow impossible by construction)
// PORTS
//  clk          in   1        single clock, all logic on rising edge
//  rst_n        in   1        synchronous, active-low reset
//  start        in   1        pulse: begin a run (honoured only in IDLE or DONE)
//  n_samples    in   CNT_W    samples per run, sampled on accepted start
//  in_valid     in   1        operand/result beat valid
//  in_ready     out  1        monitor accepts a beat
//  add_sub      in   1        0: exact = in1+in2 (unsigned); 1: exact = in1-in2 (two's complement, W+1 bits)
//  in1, in2     in   W        operands
//  res_approx   in   W+1      approximate adder result for this beat
//  busy         out  1        high in RUN and DRAIN
//  done         out  1        one-cycle pulse on entry to DONE
//  sample_cnt   out  CNT_W    beats accumulated
//  err_cnt      out  CNT_W    beats with nonzero error
//  err_sum      out  ACC_W    sum of |res_approx - exact|
//  err_max      out  W+2      largest |error|
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; pipeline valids cleared. Applies mid-run; a partial run is discarded.
//  FSM IDLE -> RUN on start; RUN -> DRAIN when accepted == n_samples; DRAIN -> DONE when both pipe stages are empty;
//   DONE -> RUN on start. start in RUN/DRAIN is ignored.
//  start with n_samples==0: RUN->DRAIN->DONE back-to-back, done 3 cycles after start, all stats 0.
//  Accepted start clears all stats and counters in the same edge.
//  in_ready = (state==RUN) && (accepted < n_samples); beat accepted when in_valid && in_ready.
//  Pipe S1 registers the beat and computes exact (W+1 bits) and diff = res_approx - exact, sign-extended to W+2.
//  Pipe S2 forms |diff| and updates the accumulators.
//  Latency: a beat accepted at edge t is reflected in the stats after edge t+2.
//  Add mode compares unsigned values; in sub mode both values are W+1-bit two's complement.
//  err_max updates when |diff| > err_max (strict); err_cnt increments when |diff| != 0.
//  Stats hold stable in DONE until the next accepted start or reset.
//  in_valid gaps are allowed in any pattern; no beat is dropped or counted twice.
// CONFIGURATION
//  ERR_SQ_EN defined:
//   - adds output err_sq_sum [2*(W+2)+CNT_W-1:0], the sum of |diff|^2 computed in S2 for MSE.
//   - err_sq_sum is cleared on reset and on start, with the same latency as err_sum.
//  ERR_SQ_EN undefined: the port is absent and no multiplier is built.
// STRUCTURE
//  Package approx_err_pkg:
//   - FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - ACC_W and square-width helper functions
//   - default W/CNT_W constants
//  Sub-module approx_err_absdiff: combinational exact computation, signed difference and absolute value
//   (W, add_sub, in1, in2, res_approx -> abs_err[W+1:0]).
//  Top level holds FSM, counters, pipeline registers and accumulators.
// TESTING
//  1. res_approx = exact, add mode, n_samples=100, random operands -> sample_cnt=100, err_cnt=0, err_sum=0, err_max=0.
//  2. res_approx = exact+3, 10 beats -> err_sum=30, err_max=3, err_cnt=10; done pulses exactly once.
//  3. Sub mode, in1=5, in2=7:
//     res_approx=27'h7FFFFFE -> error 0; res_approx=0 -> error 2, so err_max=2.
//  4. start with n_samples=0 -> done 3 cycles later, all stats 0, in_ready never high.
//  5. Random in_valid gaps, then rst_n=0 for 1 cycle mid-RUN -> state IDLE, all outputs 0, in_ready=0;
//     a fresh run of 8 beats gives sample_cnt=8.
//  6. ERR_SQ_EN: 4 beats with |error|=3 -> err_sq_sum=36, err_sum=12.

Source files
------------

// File: rtl/approx_err_pkg.sv
// Shared definitions for the approximate-adder error monitor: FSM state
// encoding, default widths and accumulator width helpers.
// The optional squared-error accumulator is enabled by defining ERR_SQ_EN.
package approx_err_pkg;

    localparam int DEFAULT_W     = 26;
    localparam int DEFAULT_CNT_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // |error| is at most 2^(W+1)-1, summed over at most 2^CNT_W-1 samples.
    function automatic int acc_width(input int w, input int cnt_w);
        return w + 1 + cnt_w;
    endfunction

    // Square of a (W+2)-bit magnitude, summed over at most 2^CNT_W-1 samples.
    function automatic int sq_width(input int w, input int cnt_w);
        return 2 * (w + 2) + cnt_w;
    endfunction

endpackage

// File: rtl/approx_err_absdiff.sv
// Combinational error magnitude for one beat: rebuilds the exact sum or
// difference, subtracts it from the approximate result and returns |diff|.
// Add mode treats both values as unsigned; sub mode treats both as
// (W+1)-bit two's complement. W+2 bits hold any difference without wrap.
module approx_err_absdiff
    import approx_err_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         add_sub,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W:0]   res_approx,
    output logic [W+1:0] abs_err
);

    logic        [W:0]   exact;
    logic signed [W+1:0] exact_x;
    logic signed [W+1:0] res_x;
    logic signed [W+1:0] diff;

    // Exact result, mode-dependent extension to W+2 bits, then magnitude
    always_comb begin
        exact   = '0;
        exact_x = '0;
        res_x   = '0;
        diff    = '0;
        abs_err = '0;
        if (add_sub) begin
            exact   = {1'b0, in1} - {1'b0, in2};
            exact_x = $signed({exact[W], exact});
            res_x   = $signed({res_approx[W], res_approx});
        end else begin
            exact   = {1'b0, in1} + {1'b0, in2};
            exact_x = $signed({1'b0, exact});
            res_x   = $signed({1'b0, res_approx});
        end
        diff    = res_x - exact_x;
        abs_err = diff[W+1] ? $unsigned(-diff) : $unsigned(diff);
    end

endmodule

// File: rtl/approx_adder_err_monitor.sv
// In-circuit error monitor for approximate adders. Accepts operand/result
// beats over valid/ready, runs them through a two-stage pipeline and
// accumulates sample count, erroneous-sample count, sum of |error| and
// max |error| over a programmed number of samples.
// Define ERR_SQ_EN to add the err_sq_sum output (sum of |error|^2).
module approx_adder_err_monitor
    import approx_err_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = DEFAULT_CNT_W,
`ifdef ERR_SQ_EN
    localparam int SQ_W = sq_width(W, CNT_W),
`endif
    localparam int ACC_W = acc_width(W, CNT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             add_sub,
    input  logic [W-1:0]     in1,
    input  logic [W-1:0]     in2,
    input  logic [W:0]       res_approx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] err_sum,
`ifdef ERR_SQ_EN
    output logic [SQ_W-1:0]  err_sq_sum,
`endif
    output logic [W+1:0]     err_max
);

    state_t           state;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] acc_cnt;
    logic             accept;
    logic             start_ok;

    logic             vld_p1;
    logic             add_sub_p1;
    logic [W-1:0]     in1_p1;
    logic [W-1:0]     in2_p1;
    logic [W:0]       res_p1;
    logic [W+1:0]     abs_p1;

    logic             vld_p2;
    logic [W+1:0]     abs_p2;

    // Beats are taken only while the run still owes samples.
    assign in_ready = (state == ST_RUN) && (acc_cnt < n_q);
    assign accept   = in_valid && in_ready;
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

    // Run control: sequencing, accepted-beat count and registered busy/done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            n_q     <= '0;
            acc_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        n_q     <= n_samples;
                        acc_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                    end
                    if (acc_cnt == n_q) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!vld_p1 && !vld_p2) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline occupancy flags; reset empties both stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
        end
    end

    // ---- S1: registered beat, exact result and error magnitude ----
    // Beat capture; data is qualified by vld_p1 and needs no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            add_sub_p1 <= add_sub;
            in1_p1     <= in1;
            in2_p1     <= in2;
            res_p1     <= res_approx;
        end
    end

    approx_err_absdiff #(
        .W (W)
    ) u_absdiff (
        .add_sub    (add_sub_p1),
        .in1        (in1_p1),
        .in2        (in2_p1),
        .res_approx (res_p1),
        .abs_err    (abs_p1)
    );

    // ---- S2: registered |error| feeding the accumulators ----
    // Magnitude capture; qualified by vld_p2
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            abs_p2 <= abs_p1;
        end
    end

`ifdef ERR_SQ_EN
    localparam int PROD_W = 2 * (W + 2);
    logic [PROD_W-1:0] sq_p2;
    assign sq_p2 = PROD_W'(abs_p2) * PROD_W'(abs_p2);
`endif

    // Statistics: cleared by reset or an accepted start, updated per S2 beat
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            err_sum    <= '0;
            err_max    <= '0;
`ifdef ERR_SQ_EN
            err_sq_sum <= '0;
`endif
        end else if (vld_p2) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (abs_p2 != '0) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            err_sum <= err_sum + ACC_W'(abs_p2);
            if (abs_p2 > err_max) begin
                err_max <= abs_p2;
            end
`ifdef ERR_SQ_EN
            err_sq_sum <= err_sq_sum + SQ_W'(sq_p2);
`endif
        end
    end

endmodule
